mdu_sequencer: RTL and testbench

//  Iterative multiply/divide unit controller for the 5-stage MIPS pipeline; owns HI/LO.

---
 rtl/mdu_sequencer_pkg.sv | 28 ++
 rtl/mdu_sequencer_step.sv | 24 ++
 rtl/mdu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes and FSM
// state encodings, plus small op-decoding helpers.
package mdu_sequencer_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // Divide ops have op[1] set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops (MULT, DIV) have op[0] clear.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_sequencer_step.sv
// Shared add/subtract step for the iterative multiply/divide datapath.
// In subtract mode carry=1 means x >= y (no borrow).
module mdu_sequencer_step
    import mdu_sequencer_pkg::*;
#(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] y_eff;

    // Two's complement subtract is add of inverted operand plus one.
    always_comb begin
        y_eff = sub ? ~y : y;
    end

    assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide controller owning HI/LO. Operands are reduced to
// magnitudes at start, 32 shift-add or restoring shift-subtract iterations run
// through the shared step, then a two-cycle fix-up applies signs and commits.
//
// Handshake: start/hilo_use are requests from EX; while busy they are not
// accepted and stall_req tells the hazard unit to hold the instruction until
// busy drops, at which point start is sampled again.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_use,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state
);

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    mdu_state_e         fsm;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   operand;
    logic [CNTW-1:0]    counter;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               zero_div;
    logic               fix_phase;

    logic [WIDTH:0]     step_x;
    logic [WIDTH:0]     step_y;
    logic [WIDTH:0]     step_sum;
    logic               step_carry;

    logic [2*WIDTH:0]   acc_mul;
    logic [2*WIDTH:0]   acc_div;
    logic [2*WIDTH:0]   acc_fix;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign busy      = (fsm != S_IDLE);
    assign stall_req = busy & (start | hilo_use);
    assign state     = fsm;

    mdu_sequencer_step #(.W(WIDTH + 1)) u_step (
        .x     (step_x),
        .y     (step_y),
        .sub   (is_div),
        .sum   (step_sum),
        .carry (step_carry)
    );

    // Step operands: mul adds to the upper half, div trials the shifted remainder.
    always_comb begin
        step_y = {1'b0, operand};
        if (is_div) begin
            step_x = acc[2*WIDTH-1:WIDTH-1];
        end else begin
            step_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
    end

    // Next accumulator for one iteration and the sign-corrected final result.
    always_comb begin
        acc_mul = acc[0] ? {1'b0, step_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};
        acc_div = step_carry ? {step_sum, acc[WIDTH-2:0], 1'b1}
                             : {step_x, acc[WIDTH-2:0], 1'b0};
        a_mag   = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
        b_mag   = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
        prod    = acc[2*WIDTH-1:0];
        quot    = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            // Divide by zero leaves remainder = |a|; its sign fix restores a.
            acc_fix = {1'b0,
                       (neg_r ? -rem : rem),
                       (zero_div ? {WIDTH{1'b1}} : (neg_q ? -quot : quot))};
        end else begin
            acc_fix = {1'b0, (neg_q ? -prod : prod)};
        end
    end

    // Controller FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk1) begin
        if (reset) begin
            fsm       <= S_IDLE;
            acc       <= '0;
            operand   <= '0;
            counter   <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_div  <= 1'b0;
            fix_phase <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (flush) begin
            fsm       <= S_IDLE;
            counter   <= '0;
            fix_phase <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (start) begin
                        fsm      <= S_CALC;
                        counter  <= '0;
                        acc      <= {{(WIDTH+1){1'b0}}, a_mag};
                        operand  <= b_mag;
                        is_div   <= op_is_div(op);
                        neg_q    <= op_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= op_is_signed(op) & op_is_div(op) & a[WIDTH-1];
                        zero_div <= op_is_div(op) & (b == '0);
                    end
                end
                S_CALC: begin
                    acc <= is_div ? acc_div : acc_mul;
                    if (counter == LAST) begin
                        counter <= '0;
                        fsm     <= S_FIX;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!fix_phase) begin
                        acc       <= acc_fix;
                        fix_phase <= 1'b1;
                    end else begin
                        hi        <= acc[2*WIDTH-1:WIDTH];
                        lo        <= acc[WIDTH-1:0];
                        done      <= 1'b1;
                        fix_phase <= 1'b0;
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: a table of multiply/divide vectors with
// hand-computed HI/LO, plus hand-written flush, reset and hazard sequences.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hilo_use = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    mdu_sequencer dut (
        .clk1      (clk1),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hilo_use  (hilo_use),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wdata     (wdata),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .state     (state)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one op and wait (bounded) for done; returns edges after the start edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        @(negedge clk1);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk1); #1;
        start = 1'b0;
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk1); #1;
            lat++;
            if (done) break;
            if (lat == 16) begin
                check({tag, " hold_hi"}, hi, model_hi);
                check({tag, " hold_lo"}, lo, model_lo);
            end
        end
        check({tag, " latency"}, lat, 34);
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MDU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
        vecs[8]  = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[11] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        // Reset state
        repeat (3) @(posedge clk1);
        @(negedge clk1); reset = 1'b0;
        @(posedge clk1); #1;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst state", {30'b0, state}, {30'b0, S_IDLE});
        hilo_use = 1'b1; #1;
        check("idle stall", {31'b0, stall_req}, 32'd0);
        hilo_use = 1'b0;

        // Table of operations
        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(tag, vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check({tag, " hi"}, hi, vecs[i].exp_hi);
            check({tag, " lo"}, lo, vecs[i].exp_lo);
            check({tag, " busy_end"}, {31'b0, busy}, 32'd0);
            model_hi = vecs[i].exp_hi;
            model_lo = vecs[i].exp_lo;
            @(posedge clk1); #1;
            check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        end

        // MTHI+MTLO together, then MTHI alone, while idle
        @(negedge clk1); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000ABCD;
        @(posedge clk1); #1; wr_hi = 1'b0; wr_lo = 1'b0;
        check("mthilo hi", hi, 32'h0000ABCD);
        check("mthilo lo", lo, 32'h0000ABCD);
        @(negedge clk1); wr_hi = 1'b1; wdata = 32'h00001234;
        @(posedge clk1); #1; wr_hi = 1'b0;
        check("mthi hi", hi, 32'h00001234);
        check("mthi lo", lo, 32'h0000ABCD);

        // Flush during DIV at counter 10: abort, HI/LO untouched, no done
        @(negedge clk1); start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk1); #1; start = 1'b0;
        repeat (10) @(posedge clk1);
        @(negedge clk1); flush = 1'b1;
        @(posedge clk1); #1; flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush hi", hi, 32'h00001234);
        check("flush lo", lo, 32'h0000ABCD);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush state", {30'b0, state}, {30'b0, S_IDLE});
        done_seen = 0;
        repeat (40) begin
            @(posedge clk1); #1;
            if (done) done_seen++;
        end
        check("flush no_done", done_seen, 0);

        // Flush and start in the same idle cycle: start dropped
        @(negedge clk1); start = 1'b1; flush = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd3;
        @(posedge clk1); #1; start = 1'b0; flush = 1'b0;
        check("flush_start busy", {31'b0, busy}, 32'd0);

        // Start with MTHI, then hazards while busy
        @(negedge clk1);
        start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd6; wr_hi = 1'b1; wdata = 32'h00000055;
        @(posedge clk1); #1; start = 1'b0; wr_hi = 1'b0;
        check("start_mthi hi", hi, 32'h00000055);
        check("start_mthi busy", {31'b0, busy}, 32'd1);
        lat = 0;
        @(negedge clk1); start = 1'b1; op = MDU_DIV; a = 32'd1; b = 32'd1; #1;
        check("stall start", {31'b0, stall_req}, 32'd1);
        start = 1'b0; hilo_use = 1'b1; #1;
        check("stall hilo", {31'b0, stall_req}, 32'd1);
        hilo_use = 1'b0; wr_lo = 1'b1; wdata = 32'h0000DEAD; start = 1'b1;
        @(posedge clk1); #1; lat++; wr_lo = 1'b0;
        check("busy mtlo lo", lo, 32'h0000ABCD);
        repeat (4) begin
            @(posedge clk1); #1; lat++;
        end
        start = 1'b0;
        check("no_restart state", {30'b0, state}, {30'b0, S_CALC});
        while (lat < 40) begin
            @(posedge clk1); #1;
            lat++;
            if (done) break;
        end
        check("hazard latency", lat, 34);
        check("hazard hi", hi, 32'd0);
        check("hazard lo", lo, 32'd30);

        // Reset mid-operation at counter 20
        @(negedge clk1); start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd7;
        @(posedge clk1); #1; start = 1'b0;
        repeat (20) @(posedge clk1);
        @(negedge clk1); reset = 1'b1;
        @(posedge clk1); #1; reset = 1'b0;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        check("midrst state", {30'b0, state}, {30'b0, S_IDLE});
        check("midrst done", {31'b0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
